// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared MDU opcode encodings, default latencies and op helpers
package mdu_ctrl_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Only the four encodings with op[2]==0 start an operation.
  function automatic logic op_valid(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[1] == 1'b1);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing {hi,lo} and div_zero
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [31:0] a_mag, b_mag, b_mag_nz, sq_mag, sr_mag, s_quo, s_rem;
  logic [31:0] b_nz, u_quo, u_rem;

  // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag    = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b[31] ? (~b + 32'd1) : b;
  assign b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign sq_mag   = a_mag / b_mag_nz;
  assign sr_mag   = a_mag % b_mag_nz;
  assign s_quo    = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign s_rem    = a[31] ? (~sr_mag + 32'd1) : sr_mag;

  assign b_nz  = (b == 32'd0) ? 32'd1 : b;
  assign u_quo = a / b_nz;
  assign u_rem = a % b_nz;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MDU_MULTU: result = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        result   = {s_rem, s_quo};
        div_zero = (b == 32'd0);
      end
      MDU_DIVU: begin
        result   = {u_rem, u_quo};
        div_zero = (b == 32'd0);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle HI/LO sequencer with pipeline stall generation
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        MDUse,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [63:0] res;
  logic        div_zero;

  mdu_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (res),
    .div_zero (div_zero)
  );

  assign stall = MDUse & (start | busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          // Any start, even an invalid op, masks the mthi/mtlo strobes.
          if (start) begin
            if (op_valid(MDUOp)) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= MDUOp;
              cnt   <= op_is_div(MDUOp) ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end else begin
            if (HIWrite) HI <= A;
            if (LOWrite) LO <= A;
          end
        end
        S_RUN: begin
          if (cnt == 4'd0) begin
            if (!div_zero) begin
              HI <= res[63:32];
              LO <= res[31:0];
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic        HIWrite, LOWrite, MDUse;
  logic [31:0] HI, LO;
  logic        busy, stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .MDUse   (MDUse),
    .HI      (HI),
    .LO      (LO),
    .busy    (busy),
    .stall   (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic begin_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
  endtask

  // Entered in the start cycle; checks n busy cycles then the idle cycle after commit.
  task automatic wait_busy(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      nxt();
      start   = 1'b0;
      HIWrite = 1'b0;
      LOWrite = 1'b0;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    nxt();
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; MDUOp = 3'b000; A = '0; B = '0;
    HIWrite = 1'b0; LOWrite = 1'b0; MDUse = 1'b0;
    nxt(); nxt();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;

    // mult: -2 * 3 = -6
    nxt();
    begin_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_busy(5, "mult");
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    chk("mult_stall_nouse", {31'd0, stall}, 32'd0);

    // divu 7/2
    begin_op(MDU_DIVU, 32'd7, 32'd2);
    wait_busy(10, "divu");
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // div -7/2
    begin_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy(10, "div");
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // div 0x80000000 / -1
    begin_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(10, "divovf");
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    // invalid op is ignored
    begin_op(3'b101, 32'd1, 32'd1);
    nxt();
    start = 1'b0;
    chk("invop_busy", {31'd0, busy}, 32'd0);

    // mthi / mtlo then divide by zero
    HIWrite = 1'b1; A = 32'h1234;
    nxt();
    HIWrite = 1'b0; LOWrite = 1'b1; A = 32'h5678;
    nxt();
    LOWrite = 1'b0;
    chk("mthi", HI, 32'h1234);
    chk("mtlo", LO, 32'h5678);
    begin_op(MDU_DIV, 32'd99, 32'd0);
    wait_busy(10, "div0");
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'h5678);

    // hazards: stall with MDUse, HIWrite and second start during RUN
    MDUse = 1'b1;
    begin_op(MDU_MULT, 32'h10, 32'h20);
    #1;
    chk("haz_stall_start", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      nxt();
      start   = 1'b0;
      HIWrite = 1'b0;
      chk("haz_busy", {31'd0, busy}, 32'd1);
      chk("haz_stall", {31'd0, stall}, 32'd1);
      chk("haz_hi_hold", HI, 32'h1234);
      chk("haz_lo_hold", LO, 32'h5678);
      if (i == 1) begin
        HIWrite = 1'b1;
        A       = 32'hDEAD;
      end
      if (i == 2) begin_op(MDU_DIVU, 32'd9, 32'd9);
    end
    nxt();
    chk("haz_done", {31'd0, busy}, 32'd0);
    chk("haz_stall_after", {31'd0, stall}, 32'd0);
    chk("haz_hi", HI, 32'd0);
    chk("haz_lo", LO, 32'h200);
    MDUse = 1'b0;

    // start + LOWrite collision in IDLE
    begin_op(MDU_MULTU, 32'd5, 32'd5);
    LOWrite = 1'b1;
    nxt();
    start = 1'b0; LOWrite = 1'b0;
    chk("coll_lo_hold", LO, 32'h200);
    chk("coll_busy", {31'd0, busy}, 32'd1);
    wait_busy(4, "coll");
    chk("coll_lo", LO, 32'd25);
    chk("coll_hi", HI, 32'd0);

    // reset in the third busy cycle of a div
    begin_op(MDU_DIV, 32'd100, 32'd7);
    nxt(); start = 1'b0;
    nxt();
    nxt();
    chk("rmid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_hi", HI, 32'd0);
    chk("rmid_lo", LO, 32'd0);
    nxt();
    reset = 1'b1;
    begin_op(MDU_MULTU, 32'd2, 32'd3);
    wait_busy(5, "rpost");
    chk("rpost_lo", LO, 32'd6);
    chk("rpost_hi", HI, 32'd0);
    for (int i = 0; i < 12; i++) nxt();
    chk("rpost_nocommit_lo", LO, 32'd6);
    chk("rpost_nocommit_hi", HI, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
